// File: rtl/conv_output_writer_pkg.sv
// Shared definitions for the convolution output writer: widths, default base
// address and the writer FSM state encoding.
package conv_output_writer_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 12;
  localparam int COUNT_W = 5;

  localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 12'h000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/conv_output_writer_row_packer.sv
// Row packer: gathers result bits into a 16-bit word, column 0 in the LSB.
// A clear and an insert in the same cycle start a fresh word whose bit 0 is
// the inserted bit, so a result arriving while a word is being written is not
// lost. word_next is exposed so the caller can capture the word including the
// bit being inserted this cycle.
module row_packer
  import conv_output_writer_pkg::*;
(
  input  logic               clk,
  input  logic               reset_b,
  input  logic               clear,
  input  logic               insert,
  input  logic               bit_in,
  output logic [DATA_W-1:0]  word_next,
  output logic [COUNT_W-1:0] count,
  output logic               overflow
);

  logic [DATA_W-1:0]  word;
  logic [COUNT_W-1:0] count_next;
  logic               full;

  assign full     = (count == COUNT_W'(DATA_W));
  assign overflow = insert & ~clear & full;

  // Next word/count: clear-with-optional-insert, or insert into the next free column.
  always_comb begin
    word_next  = word;
    count_next = count;
    if (clear) begin
      word_next    = '0;
      word_next[0] = insert & bit_in;
      count_next   = {{(COUNT_W-1){1'b0}}, insert};
    end else if (insert && !full) begin
      word_next[count[COUNT_W-2:0]] = bit_in;
      count_next                    = count + 1'b1;
    end
  end

  // Word and column count registers.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      word  <= '0;
      count <= '0;
    end else begin
      word  <= word_next;
      count <= count_next;
    end
  end

endmodule

// File: rtl/conv_output_writer.sv
// Convolution output writer: packs one 1-bit result per output column into a
// 16-bit row word and writes each row to consecutive output SRAM addresses,
// flushing a partial row when the run ends.
module conv_output_writer
  import conv_output_writer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int                WORD_W    = DATA_W
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic              result_valid,
  input  logic              result_bit,
  input  logic              row_end,
  input  logic              run_end,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [WORD_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable,
  output logic              writer_busy,
  output logic              writer_done,
  output logic              writer_err
);

  state_t             state;
  state_t             state_next;
  logic [ADDR_W-1:0]  ptr;
  logic               flush_pending;
  logic               end_req;
  logic               pk_clear;
  logic               pk_insert;
  logic               pk_overflow;
  logic [DATA_W-1:0]  pk_word_next;
  logic [COUNT_W-1:0] pk_count;

  // A run end seen during a write is remembered and acted on back in ACCUM.
  assign end_req = run_end | flush_pending;

  row_packer u_row_packer (
    .clk       (clk),
    .reset_b   (reset_b),
    .clear     (pk_clear),
    .insert    (pk_insert),
    .bit_in    (result_bit),
    .word_next (pk_word_next),
    .count     (pk_count),
    .overflow  (pk_overflow)
  );

  // Next-state decode and packer control.
  always_comb begin
    state_next = state;
    pk_clear   = 1'b0;
    pk_insert  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          pk_clear   = 1'b1;
          state_next = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        pk_insert = result_valid;
        if (row_end) begin
          state_next = ST_WRITE;
        end else if (end_req) begin
          state_next = ((pk_count != '0) || result_valid) ? ST_WRITE : ST_DONE;
        end
      end
      ST_WRITE: begin
        pk_clear   = 1'b1;
        pk_insert  = result_valid;
        state_next = flush_pending ? ST_DONE : ST_ACCUM;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state, address pointer, registered SRAM port and status flags.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state                  <= ST_IDLE;
      ptr                    <= BASE_ADDR;
      flush_pending          <= 1'b0;
      dut_sram_write_address <= BASE_ADDR;
      dut_sram_write_data    <= '0;
      dut_sram_write_enable  <= 1'b0;
      writer_busy            <= 1'b0;
      writer_done            <= 1'b0;
      writer_err             <= 1'b0;
    end else begin
      state                 <= state_next;
      dut_sram_write_enable <= (state_next == ST_WRITE);
      writer_done           <= (state_next == ST_DONE);
      if ((state_next == ST_WRITE) && (state != ST_WRITE)) begin
        dut_sram_write_address <= ptr;
        dut_sram_write_data    <= pk_word_next;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            ptr           <= BASE_ADDR;
            flush_pending <= 1'b0;
            writer_err    <= 1'b0;
            writer_busy   <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (pk_overflow) writer_err <= 1'b1;
          if (run_end) flush_pending <= 1'b1;
        end
        ST_WRITE: begin
          ptr           <= ptr + 1'b1;
          if (row_end) writer_err <= 1'b1;
          flush_pending <= flush_pending ? 1'b0 : run_end;
        end
        ST_DONE: begin
          writer_busy   <= 1'b0;
          flush_pending <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_output_writer.sv
// Testbench for conv_output_writer: a transaction-level model of rows, writes
// and run completion schedules the expected outputs per cycle; a compare
// process checks every cycle, and directed scenarios pin literal values.
module tb_conv_output_writer;
  import conv_output_writer_pkg::*;

  localparam logic [11:0] BASE = 12'h000;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        start = 1'b0;
  logic        result_valid = 1'b0;
  logic        result_bit = 1'b0;
  logic        row_end = 1'b0;
  logic        run_end = 1'b0;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        busy;
  logic        done;
  logic        err;

  conv_output_writer #(.BASE_ADDR(BASE), .WORD_W(16)) dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .start                  (start),
    .result_valid           (result_valid),
    .result_bit             (result_bit),
    .row_end                (row_end),
    .run_end                (run_end),
    .dut_sram_write_address (wr_addr),
    .dut_sram_write_data    (wr_data),
    .dut_sram_write_enable  (wr_en),
    .writer_busy            (busy),
    .writer_done            (done),
    .writer_err             (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  // Behavioural model state
  bit          m_active = 1'b0;
  logic [15:0] m_word = '0;
  int          m_cnt = 0;
  logic [11:0] m_ptr = BASE;
  logic        m_busy = 1'b0;
  logic        m_err = 1'b0;
  logic [11:0] m_last_addr = BASE;
  logic [15:0] m_last_data = '0;
  logic [11:0] exp_addr[int];
  logic [15:0] exp_data[int];
  bit          exp_done[int];
  bit          busy_chg[int];
  bit          err_chg[int];

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t seen_q[$];
  int  done_cyc = -1;
  int  run_end_cyc = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic schedule_write(input int k);
    exp_addr[k] = m_ptr;
    exp_data[k] = m_word;
    m_ptr  = m_ptr + 12'd1;
    m_word = '0;
    m_cnt  = 0;
  endtask

  task automatic finish_run(input int k);
    exp_done[k]   = 1'b1;
    busy_chg[k+1] = 1'b0;
    m_active      = 1'b0;
  endtask

  task automatic model_reset();
    exp_addr.delete();
    exp_data.delete();
    exp_done.delete();
    busy_chg.delete();
    err_chg.delete();
    m_active    = 1'b0;
    m_word      = '0;
    m_cnt       = 0;
    m_busy      = 1'b0;
    m_err       = 1'b0;
    m_last_addr = BASE;
    m_last_data = '0;
  endtask

  // Drive one cycle of inputs and advance the model; effects appear next cycle.
  task automatic applyStimulus(input bit s, input bit v, input bit b, input bit re, input bit rn);
    int c;
    @(posedge clk);
    #1;
    start        = s;
    result_valid = v;
    result_bit   = b;
    row_end      = re;
    run_end      = rn;
    c = cyc;
    if (rn) run_end_cyc = c;
    if (!m_active) begin
      if (s) begin
        m_active      = 1'b1;
        m_ptr         = BASE;
        m_word        = '0;
        m_cnt         = 0;
        err_chg[c+1]  = 1'b0;
        busy_chg[c+1] = 1'b1;
      end
    end else begin
      if (v) begin
        if (m_cnt < 16) begin
          m_word[m_cnt] = b;
          m_cnt++;
        end else begin
          err_chg[c+1] = 1'b1;
        end
      end
      if (re) begin
        schedule_write(c + 1);
        if (rn) finish_run(c + 2);
      end else if (rn) begin
        if (m_cnt > 0) begin
          schedule_write(c + 1);
          finish_run(c + 2);
        end else begin
          finish_run(c + 1);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (wr_en === 1'b1) seen_q.push_back(wr_t'{addr: wr_addr, data: wr_data});
    if (done === 1'b1) done_cyc = cyc;
    if (checking && reset_b) begin
      if (busy_chg.exists(cyc)) m_busy = busy_chg[cyc];
      if (err_chg.exists(cyc)) m_err = err_chg[cyc];
      if (exp_addr.exists(cyc)) begin
        m_last_addr = exp_addr[cyc];
        m_last_data = exp_data[cyc];
      end
      checkOutput("write_enable", 32'(wr_en), 32'(exp_addr.exists(cyc)));
      checkOutput("write_address", 32'(wr_addr), 32'(m_last_addr));
      checkOutput("write_data", 32'(wr_data), 32'(m_last_data));
      checkOutput("writer_done", 32'(done), 32'(exp_done.exists(cyc)));
      checkOutput("writer_busy", 32'(busy), 32'(m_busy));
      checkOutput("writer_err", 32'(err), 32'(m_err));
    end
  end

  task automatic run_three_bits(input string tag);
    seen_q.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    checkOutput({tag, "_writes"}, 32'(seen_q.size()), 32'd1);
    if (seen_q.size() >= 1) begin
      checkOutput({tag, "_addr"}, 32'(seen_q[0].addr), 32'h000);
      checkOutput({tag, "_data"}, 32'(seen_q[0].data), 32'h0005);
    end
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_done_lat"}, 32'(done_cyc - run_end_cyc), 32'd1);
  endtask

  task automatic runRandom(input int nrows);
    int n;
    int mode;
    bit last;
    bit want_re;
    bit joined;
    bit re;
    mode = $urandom_range(0, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < nrows; r++) begin
      last    = (r == nrows - 1);
      want_re = !(last && mode == 2);
      n       = $urandom_range(0, 18);
      joined  = want_re && (n > 0) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0)
          applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
        re = joined && (i == n - 1);
        applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), re, re && last && (mode == 0));
      end
      if (want_re && !joined) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, last && (mode == 0));
      if (want_re) begin
        if (last && mode == 0) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        else applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
    end
    if (mode != 0)
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    idle(4);
  endtask

  initial begin
    #1_000_000;
    n_err++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_we", 32'(wr_en), 32'd0);
    checkOutput("reset_addr", 32'(wr_addr), 32'(BASE));
    checkOutput("reset_data", 32'(wr_data), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    @(negedge clk);
    reset_b  = 1'b1;
    model_reset();
    checking = 1'b1;
    idle(2);

    // Three results 1,0,1 (plus an ignored start mid-run)
    run_three_bits("t1");

    // Two rows of fourteen ones, run_end after the second row
    seen_q.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int row = 0; row < 2; row++) begin
      repeat (14) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    checkOutput("t2_writes", 32'(seen_q.size()), 32'd2);
    if (seen_q.size() >= 2) begin
      checkOutput("t2_addr0", 32'(seen_q[0].addr), 32'h000);
      checkOutput("t2_data0", 32'(seen_q[0].data), 32'h3FFF);
      checkOutput("t2_addr1", 32'(seen_q[1].addr), 32'h001);
      checkOutput("t2_data1", 32'(seen_q[1].data), 32'h3FFF);
    end
    checkOutput("t2_done_lat", 32'(done_cyc - run_end_cyc), 32'd1);

    // Five results then run_end: flush write
    seen_q.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    checkOutput("t3_writes", 32'(seen_q.size()), 32'd1);
    if (seen_q.size() >= 1) checkOutput("t3_data", 32'(seen_q[0].data), 32'h001F);
    checkOutput("t3_done_lat", 32'(done_cyc - run_end_cyc), 32'd2);

    // Seventeen results in one row: overflow, sticky error
    seen_q.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (17) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    if (seen_q.size() >= 1) checkOutput("t4_data", 32'(seen_q[0].data), 32'hFFFF);
    else checkOutput("t4_writes", 32'(seen_q.size()), 32'd1);
    checkOutput("t4_err_sticky", 32'(err), 32'd1);

    // Reset asserted during the second row's write
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checking = 1'b0;
    row_end  = 1'b0;
    checkOutput("t6_pre_we", 32'(wr_en), 32'd1);
    checkOutput("t6_pre_addr", 32'(wr_addr), 32'h001);
    checkOutput("t6_pre_data", 32'(wr_data), 32'h0002);
    reset_b = 1'b0;
    #1;
    checkOutput("t6_rst_we", 32'(wr_en), 32'd0);
    checkOutput("t6_rst_addr", 32'(wr_addr), 32'(BASE));
    checkOutput("t6_rst_data", 32'(wr_data), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset_b = 1'b1;
    model_reset();
    checking = 1'b1;
    idle(2);
    run_three_bits("t6_restart");

    // Randomized runs
    repeat (14) runRandom($urandom_range(1, 4));

    // Address pointer wrap: 4097 single-bit rows
    seen_q.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4097; i++) begin
      applyStimulus(1'b0, 1'b1, 1'(i % 2), 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    checkOutput("wrap_writes", 32'(seen_q.size()), 32'd4097);
    if (seen_q.size() >= 4097) begin
      checkOutput("wrap_addr_fff", 32'(seen_q[4095].addr), 32'hFFF);
      checkOutput("wrap_data_fff", 32'(seen_q[4095].data), 32'h0001);
      checkOutput("wrap_addr_000", 32'(seen_q[4096].addr), 32'h000);
      checkOutput("wrap_data_000", 32'(seen_q[4096].data), 32'h0000);
    end

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
